// File: rtl/beat_sequencer_if.sv
// Panel/controller bundle for the beat sequencer.
// Inputs: qd, sw, step, short_req, long_req, stop. Outputs: w1..w3, running, cyc_end, cyc_cnt, abort.
interface beat_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             qd;
   logic [2:0]       sw;
   logic             step;
   logic             short_req;
   logic             long_req;
   logic             stop;
   logic             w1;
   logic             w2;
   logic             w3;
   logic             running;
   logic             cyc_end;
   logic [CNT_W-1:0] cyc_cnt;
   logic             abort;

   modport master (
      output qd, sw, step, short_req, long_req, stop,
      input  w1, w2, w3, running, cyc_end, cyc_cnt, abort
   );

   modport slave (
      input  qd, sw, step, short_req, long_req, stop,
      output w1, w2, w3, running, cyc_end, cyc_cnt, abort
   );
endinterface

// File: rtl/beat_sequencer.sv
// W1/W2/W3 beat generator: starts on a qd rising edge, honours short/long/stop.
// Ports: t3 clock, clr async active-low reset, bus = beat_sequencer_if.slave.
module beat_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic               t3,
   input  logic               clr,
   beat_sequencer_if.slave    bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      W1   = 2'd1,
      W2   = 2'd2,
      W3   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             qd_q;
   logic [2:0]       sw_q, sw_d;
   logic             abort_q, abort_d;
   logic             cyc_end_q, cyc_end_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last;

   always_ff @(posedge t3 or negedge clr) begin
      if (!clr) begin
         state_q   <= IDLE;
         qd_q      <= 1'b0;
         sw_q      <= 3'b000;
         abort_q   <= 1'b0;
         cyc_end_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         qd_q      <= bus.qd;
         sw_q      <= sw_d;
         abort_q   <= abort_d;
         cyc_end_q <= cyc_end_d;
         cnt_q     <= cnt_d;
      end
   end

   // short is only looked at in W1, long only in W2; W3 always ends.
   always_comb begin
      last = 1'b0;
      unique case (state_q)
         W1:      last = bus.short_req;
         W2:      last = !bus.long_req;
         W3:      last = 1'b1;
         default: last = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sw_d      = sw_q;
      abort_d   = abort_q;
      cyc_end_d = 1'b0;
      cnt_d     = cnt_q;
      if (state_q == IDLE) begin
         if (bus.qd && !qd_q) begin
            state_d = W1;
            sw_d    = bus.sw;
            abort_d = 1'b0;
         end
      end else if (bus.sw != sw_q) begin
         // Mode changed mid-run: drop the cycle without counting it.
         state_d = IDLE;
         abort_d = 1'b1;
      end else if (bus.stop) begin
         state_d = IDLE;
         if (last) begin
            cyc_end_d = 1'b1;
            cnt_d     = cnt_q + 1'b1;
         end
      end else if (last) begin
         cyc_end_d = 1'b1;
         cnt_d     = cnt_q + 1'b1;
         state_d   = bus.step ? IDLE : W1;
      end else begin
         unique case (state_q)
            W1:      state_d = W2;
            W2:      state_d = W3;
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.w1      = (state_q == W1);
   assign bus.w2      = (state_q == W2);
   assign bus.w3      = (state_q == W3);
   assign bus.running = (state_q != IDLE);
   assign bus.cyc_end = cyc_end_q;
   assign bus.cyc_cnt = cnt_q;
   assign bus.abort   = abort_q;
endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with a queue of expected output snapshots.
// Each step pushes the expectation, advances one t3 edge, then pops and compares.
module tb_beat_sequencer;
   logic t3;
   logic clr;
   int   checks;
   int   failures;

   beat_sequencer_if #(.CNT_W(8)) bif ();

   beat_sequencer #(.CNT_W(8)) dut (
      .t3  (t3),
      .clr (clr),
      .bus (bif.slave)
   );

   typedef struct {
      string      tag;
      logic [2:0] w;
      logic       ce;
      logic [7:0] cnt;
      logic       ab;
   } exp_t;

   exp_t sb[$];

   initial t3 = 1'b0;
   always #5 t3 = ~t3;

   task automatic push(input string tag, input logic [2:0] w,
                       input logic ce, input int cnt, input logic ab);
      exp_t e;
      e.tag = tag;
      e.w   = w;
      e.ce  = ce;
      e.cnt = cnt[7:0];
      e.ab  = ab;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t        e;
      logic [12:0] obs;
      logic [12:0] req;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty obs=none exp=entry");
      end else begin
         e   = sb.pop_front();
         obs = {bif.w1, bif.w2, bif.w3, bif.running,
                bif.cyc_end, bif.cyc_cnt, bif.abort};
         req = {e.w, |e.w, e.ce, e.cnt, e.ab};
         assert (obs === req) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", e.tag, obs, req);
         end
      end
   endtask

   task automatic tick(input string tag, input logic [2:0] w,
                       input logic ce, input int cnt, input logic ab);
      push(tag, w, ce, cnt, ab);
      @(posedge t3);
      #1;
      compare();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clr           = 1'b0;
      bif.qd        = 1'b0;
      bif.sw        = 3'b000;
      bif.step      = 1'b0;
      bif.short_req = 1'b0;
      bif.long_req  = 1'b0;
      bif.stop      = 1'b0;
      #12;
      push("reset", 3'b000, 0, 0, 0);
      compare();
      @(negedge t3);
      clr = 1'b1;
      tick("idle", 3'b000, 0, 0, 0);

      // Plain two-beat cycles
      bif.qd = 1'b1;
      tick("start_w1", 3'b100, 0, 0, 0);
      bif.qd = 1'b0;
      tick("plain_w2", 3'b010, 0, 0, 0);
      tick("plain_c1", 3'b100, 1, 1, 0);
      tick("plain_w2b", 3'b010, 0, 1, 0);
      tick("plain_c2", 3'b100, 1, 2, 0);

      // Short: one-beat cycles, then stop on last beat counts
      bif.short_req = 1'b1;
      tick("short_c3", 3'b100, 1, 3, 0);
      tick("short_c4", 3'b100, 1, 4, 0);
      bif.stop = 1'b1;
      tick("short_stop", 3'b000, 1, 5, 0);
      bif.stop      = 1'b0;
      bif.short_req = 1'b0;
      tick("stop_idle", 3'b000, 0, 5, 0);

      // Long: three-beat cycle, qd held high must not retrigger
      bif.qd       = 1'b1;
      bif.long_req = 1'b1;
      tick("long_w1", 3'b100, 0, 5, 0);
      tick("long_w2", 3'b010, 0, 5, 0);
      tick("long_w3", 3'b001, 0, 5, 0);
      tick("long_c6", 3'b100, 1, 6, 0);
      bif.short_req = 1'b1;
      tick("shortlong", 3'b100, 1, 7, 0);
      bif.short_req = 1'b0;
      bif.long_req  = 1'b0;
      bif.qd        = 1'b0;
      bif.stop      = 1'b1;
      tick("stop_mid", 3'b000, 0, 7, 0);
      bif.stop = 1'b0;

      // Single-cycle step mode
      bif.step = 1'b1;
      bif.qd   = 1'b1;
      tick("step_w1", 3'b100, 0, 7, 0);
      bif.qd = 1'b0;
      tick("step_w2", 3'b010, 0, 7, 0);
      tick("step_end", 3'b000, 1, 8, 0);
      tick("step_hold", 3'b000, 0, 8, 0);
      bif.qd = 1'b1;
      tick("step2_w1", 3'b100, 0, 8, 0);
      bif.qd = 1'b0;
      tick("step2_w2", 3'b010, 0, 8, 0);
      tick("step2_end", 3'b000, 1, 9, 0);
      bif.step = 1'b0;

      // Mode change aborts, next start clears abort
      bif.qd = 1'b1;
      tick("ab_w1", 3'b100, 0, 9, 0);
      bif.qd = 1'b0;
      tick("ab_w2", 3'b010, 0, 9, 0);
      bif.sw = 3'b010;
      tick("abort", 3'b000, 0, 9, 1);
      tick("abort_sticky", 3'b000, 0, 9, 1);
      bif.qd = 1'b1;
      tick("abort_clr", 3'b100, 0, 9, 0);
      bif.qd = 1'b0;

      // Counter wrap with one-beat cycles
      bif.short_req = 1'b1;
      for (int i = 10; i <= 257; i++) begin
         tick("wrap", 3'b100, 1, i % 256, 0);
      end
      bif.short_req = 1'b0;
      tick("pre_w2", 3'b010, 0, 1, 0);
      bif.long_req = 1'b1;
      tick("pre_w3", 3'b001, 0, 1, 0);

      // Async clear in W3, no edge needed
      #2;
      clr = 1'b0;
      #1;
      push("async_clr", 3'b000, 0, 0, 0);
      compare();
      bif.long_req = 1'b0;
      @(negedge t3);
      clr = 1'b1;
      tick("post_clr", 3'b000, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
